edge_event_arbiter: RTL and testbench

- Monitors N_CH asynchronous level signals and synchronises each one.
- Detects rising and/or falling edges per channel, as selected by a per-channel mode.
- Queues one pending event per channel and serialises events onto a single valid/ready event port using round-robin arbitration.
- Sits between raw status/strobe inputs and the single consumer that services edge events. It replaces ad-hoc per-signal edge detectors.

---
 rtl/edge_event_arbiter_pkg.sv | 9 +
 rtl/edge_event_arbiter_edge_det_ch.sv | 33 +++
 rtl/edge_event_arbiter.sv | 87 ++++++++
 tb/tb_edge_event_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/edge_event_arbiter_pkg.sv
// edge_event_arbiter_pkg: shared mode and polarity encodings for the edge event arbiter
package edge_event_arbiter_pkg;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  localparam logic POL_FALL = 1'b0;
  localparam logic POL_RISE = 1'b1;
endpackage

// File: rtl/edge_event_arbiter_edge_det_ch.sv
// edge_det_ch: per-channel synchroniser, previous-value register and mode-qualified edge pulses
module edge_det_ch
  import edge_event_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig_i,
  input  logic [1:0] mode_i,
  input  logic       en_i,
  output logic       rise_o,
  output logic       fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  assign s = sync_q[SYNC_STAGES-1];
  // prev keeps tracking during warm-up so a level held through reset never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= s;
    end
  end
  always_comb begin
    rise_o = en_i & s & ~prev_q & ((mode_i == MODE_RISE) | (mode_i == MODE_BOTH));
    fall_o = en_i & ~s & prev_q & ((mode_i == MODE_FALL) | (mode_i == MODE_BOTH));
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detection serialised onto one valid/ready port by round-robin
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sig_in,
  input  logic [2*N_CH-1:0] mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_pol,
  output logic [N_CH-1:0]   ovf,
  input  logic              ovf_clr
);
  localparam int WU_W = $clog2(SYNC_STAGES + 2);
  logic [WU_W-1:0] wu_q, wu_d;
  logic [N_CH-1:0] rise, fall, edg, gnt, acc;
  logic [N_CH-1:0] pend_q, pend_d, pol_q, pol_d, ovf_q, ovf_d;
  logic            valid_q, valid_d, epol_q, epol_d, load, found, grant;
  logic [CH_W-1:0] ch_q, ch_d, last_q, last_d, sel;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    edge_det_ch #(.SYNC_STAGES(SYNC_STAGES)) u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_in[c]),
      .mode_i (mode[2*c +: 2]),
      .en_i   (wu_q == '0),
      .rise_o (rise[c]),
      .fall_o (fall[c])
    );
  end
  always_comb begin
    wu_d  = (wu_q != '0) ? wu_q - 1'b1 : wu_q;
    load  = ~valid_q | evt_ready;
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!found && pend_q[(int'(last_q) + i) % N_CH]) begin
        found = 1'b1;
        sel   = CH_W'((int'(last_q) + i) % N_CH);
      end
    end
    grant    = load & found;
    gnt      = '0;
    gnt[sel] = grant;
    edg      = rise | fall;
    // an edge on the channel being granted this cycle refills its slot instead of overflowing
    acc      = edg & (~pend_q | gnt);
    pend_d   = (pend_q & ~gnt) | edg;
    pol_d    = (acc & rise) | (~acc & pol_q);
    ovf_d    = (ovf_q & {N_CH{~ovf_clr}}) | (edg & pend_q & ~gnt);
    valid_d  = load ? found : valid_q;
    ch_d     = grant ? sel : ch_q;
    epol_d   = grant ? pol_q[sel] : epol_q;
    last_d   = grant ? sel : last_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wu_q    <= WU_W'(SYNC_STAGES + 1);
      pend_q  <= '0;
      pol_q   <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      epol_q  <= POL_FALL;
      last_q  <= CH_W'(N_CH - 1);
    end else begin
      wu_q    <= wu_d;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      epol_q  <= epol_d;
      last_q  <= last_d;
    end
  end
  assign evt_valid = valid_q;
  assign evt_ch    = ch_q;
  assign evt_pol   = epol_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scenario bench for edge_event_arbiter at default parameters
module tb_edge_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_in = '0;
  logic [7:0] mode = '0;
  logic       evt_valid, evt_ready = 1'b1, evt_pol, ovf_clr = 1'b0;
  logic [1:0] evt_ch;
  logic [3:0] ovf;
  int total = 0;
  int bad = 0;

  edge_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .mode      (mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    sig_in = '0;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    repeat (6) step;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sig_in = 4'hF; mode = 8'hFF; evt_ready = 1'b1; ovf_clr = 1'b0;
    step; step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
    total++; if (evt_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", evt_ch); end
    total++; if (evt_pol !== 1'b0) begin bad++; $display("FAIL reset_pol got=%0b exp=0", evt_pol); end
    total++; if (ovf !== 4'h0) begin bad++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL warmup_valid cyc=%0d got=%0b exp=0", i, evt_valid); end
    end
    total++; if (ovf !== 4'h0) begin bad++; $display("FAIL warmup_ovf got=%0h exp=0", ovf); end
    mode = 8'h00; sig_in = 4'h0;
    repeat (6) step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_single;
    mode = 8'h10; sig_in = 4'h4;
    repeat (3) step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", evt_valid); end
    step;
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", evt_valid); end
    total++; if (evt_ch !== 2'd2) begin bad++; $display("FAIL single_ch got=%0d exp=2", evt_ch); end
    total++; if (evt_pol !== 1'b1) begin bad++; $display("FAIL single_pol got=%0b exp=1", evt_pol); end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_round_robin;
    do_reset;
    mode = 8'h55; sig_in = 4'hF;
    repeat (3) step;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (evt_valid !== 1'b1 || evt_ch !== 2'(i)) begin bad++; $display("FAIL rr1_ch slot=%0d got=%0b/%0d exp=1/%0d", i, evt_valid, evt_ch, i); end
    end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr1_end got=%0b exp=0", evt_valid); end
    sig_in = 4'h0;
    repeat (6) step;
    sig_in = 4'h2;
    repeat (4) step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL rr_prime got=%0b/%0d exp=1/1", evt_valid, evt_ch); end
    step;
    sig_in = 4'h0;
    repeat (6) step;
    sig_in = 4'hF;
    repeat (3) step;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (evt_valid !== 1'b1 || evt_ch !== 2'(i + 2)) begin bad++; $display("FAIL rr2_ch slot=%0d got=%0b/%0d exp=1/%0d", i, evt_valid, evt_ch, (i + 2) % 4); end
    end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr2_end got=%0b exp=0", evt_valid); end
  endtask

  task automatic test_backpressure;
    evt_ready = 1'b0; sig_in = 4'h0;
    repeat (6) step;
    sig_in = 4'h2;
    repeat (4) step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin bad++; $display("FAIL bp_first got=%0b/%0d/%0b exp=1/1/1", evt_valid, evt_ch, evt_pol); end
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) sig_in = 4'h0;
      if (i == 4 || i == 12) sig_in = 4'h2;
      step;
      total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0b/%0d/%0b exp=1/1/1", i, evt_valid, evt_ch, evt_pol); end
    end
    total++; if (ovf !== 4'h2) begin bad++; $display("FAIL bp_ovf got=%0h exp=2", ovf); end
    evt_ready = 1'b1;
    step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_pol !== 1'b1) begin bad++; $display("FAIL bp_second got=%0b/%0d/%0b exp=1/1/1", evt_valid, evt_ch, evt_pol); end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", evt_valid); end
    total++; if (ovf !== 4'h2) begin bad++; $display("FAIL bp_ovf_sticky got=%0h exp=2", ovf); end
  endtask

  task automatic test_mode_filter;
    mode = 8'h02; sig_in = 4'h3;
    repeat (4) step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mf_rise_ignored got=%0b exp=0", evt_valid); end
    sig_in = 4'h2;
    repeat (3) step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mf_early got=%0b exp=0", evt_valid); end
    step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b0) begin bad++; $display("FAIL mf_fall got=%0b/%0d/%0b exp=1/0/0", evt_valid, evt_ch, evt_pol); end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mf_single got=%0b exp=0", evt_valid); end
    mode = 8'h00; sig_in = 4'h3;
    repeat (4) step;
    sig_in = 4'h2;
    for (int i = 0; i < 8; i++) begin
      step;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mf_off cyc=%0d got=%0b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_ovf_clear;
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    total++; if (ovf !== 4'h0) begin bad++; $display("FAIL ovf_clr got=%0h exp=0", ovf); end
    evt_ready = 1'b0; mode = 8'hC0; sig_in = 4'hA;
    repeat (4) step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_pol !== 1'b1) begin bad++; $display("FAIL ovf_ch3 got=%0b/%0d/%0b exp=1/3/1", evt_valid, evt_ch, evt_pol); end
    sig_in = 4'h2;
    repeat (3) step;
    sig_in = 4'hA;
    repeat (2) step;
    ovf_clr = 1'b1;
    step;
    ovf_clr = 1'b0;
    total++; if (ovf !== 4'h8) begin bad++; $display("FAIL ovf_set_wins got=%0h exp=8", ovf); end
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_pol !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%0b/%0d/%0b exp=1/3/1", evt_valid, evt_ch, evt_pol); end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    step;
    total++; if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || evt_pol !== 1'b0) begin bad++; $display("FAIL rmid_out got=%0b/%0d/%0b exp=0/0/0", evt_valid, evt_ch, evt_pol); end
    total++; if (ovf !== 4'h0) begin bad++; $display("FAIL rmid_ovf got=%0h exp=0", ovf); end
    rst_n = 1'b1; evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_warmup cyc=%0d got=%0b exp=0", i, evt_valid); end
    end
  endtask

  task automatic test_back_to_back;
    mode = 8'h03; sig_in = 4'hB;
    step;
    sig_in = 4'hA;
    repeat (2) step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_early got=%0b exp=0", evt_valid); end
    step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b1) begin bad++; $display("FAIL b2b_rise got=%0b/%0d/%0b exp=1/0/1", evt_valid, evt_ch, evt_pol); end
    step;
    total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_pol !== 1'b0) begin bad++; $display("FAIL b2b_fall got=%0b/%0d/%0b exp=1/0/0", evt_valid, evt_ch, evt_pol); end
    step;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b exp=0", evt_valid); end
    total++; if (ovf !== 4'h0) begin bad++; $display("FAIL b2b_ovf got=%0h exp=0", ovf); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_mode_filter;
    test_ovf_clear;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
